// File: rtl/ps2_key_decoder.sv
// ============================================================================
// ps2_key_decoder
// ----------------------------------------------------------------------------
// Turns the PS/2 set-2 scan-code byte stream from the frame receiver into
// ASCII characters. The block tracks the break (0xF0) and extended (0xE0)
// prefixes, the Shift keys and Caps Lock. It queues the decoded characters in
// a show-ahead FIFO that a ready/valid consumer drains.
//
// Data path:
//   code_in --> prefix FSM + key map --> decode register --> FIFO --> ascii
//   edge E samples the byte; edge E+1 writes the FIFO.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   code_in      scan-code byte from the receiver
//   code_valid   one-cycle strobe marking code_in valid
//   ascii        FIFO head character, 0x00 when empty
//   ascii_valid  FIFO non-empty
//   ascii_ready  consumer takes the head when ascii_valid && ascii_ready
//   shift_held   either Shift key currently down
//   caps_lock    Caps Lock toggle state
//   key_count    completed non-extended key releases, wraps 255 -> 0
//   overflow     sticky: a character was dropped because the FIFO was full
// ============================================================================
module ps2_key_decoder #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic [7:0] ascii,
    output logic       ascii_valid,
    input  logic       ascii_ready,
    output logic       shift_held,
    output logic       caps_lock,
    output logic [7:0] key_count,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    // ------------------------------------------------------------------------
    // Key map. Returns {hit, character}. The caller supplies the letter-case
    // selector, so the map stays free of state.
    // ------------------------------------------------------------------------
    function automatic logic [8:0] map_code(input logic [7:0] code,
                                            input logic       upper);
        logic [4:0] letter;
        logic       is_letter;
        logic [8:0] result;
        letter    = 5'd0;
        is_letter = 1'b1;
        result    = 9'd0;
        case (code)
            8'h1C: letter = 5'd0;    // a
            8'h32: letter = 5'd1;    // b
            8'h21: letter = 5'd2;    // c
            8'h23: letter = 5'd3;    // d
            8'h24: letter = 5'd4;    // e
            8'h2B: letter = 5'd5;    // f
            8'h34: letter = 5'd6;    // g
            8'h33: letter = 5'd7;    // h
            8'h43: letter = 5'd8;    // i
            8'h3B: letter = 5'd9;    // j
            8'h42: letter = 5'd10;   // k
            8'h4B: letter = 5'd11;   // l
            8'h3A: letter = 5'd12;   // m
            8'h31: letter = 5'd13;   // n
            8'h44: letter = 5'd14;   // o
            8'h4D: letter = 5'd15;   // p
            8'h15: letter = 5'd16;   // q
            8'h2D: letter = 5'd17;   // r
            8'h1B: letter = 5'd18;   // s
            8'h2C: letter = 5'd19;   // t
            8'h3C: letter = 5'd20;   // u
            8'h2A: letter = 5'd21;   // v
            8'h1D: letter = 5'd22;   // w
            8'h22: letter = 5'd23;   // x
            8'h35: letter = 5'd24;   // y
            8'h1A: letter = 5'd25;   // z
            default: is_letter = 1'b0;
        endcase

        if (is_letter) begin
            result = {1'b1, (upper ? 8'h41 : 8'h61) + {3'b000, letter}};
        end else begin
            case (code)
                8'h45: result = {1'b1, 8'h30};
                8'h16: result = {1'b1, 8'h31};
                8'h1E: result = {1'b1, 8'h32};
                8'h26: result = {1'b1, 8'h33};
                8'h25: result = {1'b1, 8'h34};
                8'h2E: result = {1'b1, 8'h35};
                8'h36: result = {1'b1, 8'h36};
                8'h3D: result = {1'b1, 8'h37};
                8'h3E: result = {1'b1, 8'h38};
                8'h46: result = {1'b1, 8'h39};
                8'h29: result = {1'b1, 8'h20};   // space
                8'h5A: result = {1'b1, 8'h0D};   // enter
                8'h66: result = {1'b1, 8'h08};   // backspace
                default: result = 9'd0;
            endcase
        end
        return result;
    endfunction

    // ------------------------------------------------------------------------
    // Prefix FSM and key state
    // ------------------------------------------------------------------------
    state_t     state, state_next;
    logic       lshift, lshift_next;
    logic       rshift, rshift_next;
    logic       caps_next;
    logic [7:0] key_count_next;
    logic       dec_push, dec_push_next;
    logic [7:0] dec_char, dec_char_next;
    logic [8:0] mapped;

    // The map sees the Shift/Caps state registered before this byte.
    assign mapped = map_code(code_in, shift_held ^ caps_lock);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next     = state;
        lshift_next    = lshift;
        rshift_next    = rshift;
        caps_next      = caps_lock;
        key_count_next = key_count;
        dec_push_next  = 1'b0;
        dec_char_next  = 8'h00;

        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code_in == CODE_BREAK) begin
                        state_next = BRK;
                    end else if (code_in == CODE_EXT) begin
                        state_next = EXT;
                    end else if (code_in == CODE_LSHIFT) begin
                        lshift_next = 1'b1;
                    end else if (code_in == CODE_RSHIFT) begin
                        rshift_next = 1'b1;
                    end else if (code_in == CODE_CAPS) begin
                        caps_next = ~caps_lock;
                    end else begin
                        dec_push_next = mapped[8];
                        dec_char_next = mapped[7:0];
                    end
                end
                BRK: begin
                    key_count_next = key_count + 8'd1;
                    if (code_in == CODE_LSHIFT) lshift_next = 1'b0;
                    if (code_in == CODE_RSHIFT) rshift_next = 1'b0;
                    state_next = IDLE;
                end
                EXT: begin
                    // Extended makes are not mapped; only a following break
                    // prefix keeps the sequence alive.
                    state_next = (code_in == CODE_BREAK) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_lock <= 1'b0;
            key_count <= 8'd0;
            dec_push  <= 1'b0;
            dec_char  <= 8'h00;
        end else begin
            state     <= state_next;
            lshift    <= lshift_next;
            rshift    <= rshift_next;
            caps_lock <= caps_next;
            key_count <= key_count_next;
            dec_push  <= dec_push_next;
            dec_char  <= dec_char_next;
        end
    end

    assign shift_held = lshift | rshift;

    // ------------------------------------------------------------------------
    // Show-ahead FIFO
    // ------------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             pop;
    logic             push_ok;

    assign full        = (count == CNT_W'(DEPTH));
    assign ascii_valid = (count != '0);
    assign pop         = ascii_valid & ascii_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok     = dec_push & (~full | pop);
    assign ascii       = ascii_valid ? mem[rd_ptr] : 8'h00;

    // NOTE: the storage array has no reset; count gates every read, so stale
    // contents are never visible and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= dec_char;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (dec_push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Converts the PS/2 scan-code byte stream (set 2) from the keyboard receiver into ASCII characters. It tracks the break (0xF0) and extended (0xE0) prefixes and the Shift and Caps Lock state, and buffers the characters in a small show-ahead FIFO for a ready/valid consumer. It sits directly downstream of the PS/2 frame receiver, which delivers one validated data byte per frame, and upstream of display or terminal logic.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- code_in  in  8  scan-code byte from receiver
- code_valid  in  1  one-cycle strobe; code_in is valid this cycle
- ascii  out  8  FIFO head character; 0x00 when empty
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer accepts head when ascii_valid && ascii_ready
- shift_held  out  1  either Shift key currently down
- caps_lock  out  1  Caps Lock toggle state
- key_count  out  8  count of completed non-extended key releases, wraps 255->0
- overflow  out  1  sticky; a character was dropped because the FIFO was full

## Operation
- Prefix FSM states: IDLE, BRK (0xF0 seen), EXT (0xE0 seen), EXT_BRK (0xE0 then 0xF0 seen). Only cycles with code_valid advance the FSM.
- IDLE:
  - 0xF0 -> BRK.
  - 0xE0 -> EXT.
  - Any other byte is a make code: apply it, stay in IDLE.
- BRK: any byte is a break code: apply the release, key_count += 1, -> IDLE.
- EXT:
  - 0xF0 -> EXT_BRK.
  - Any other byte: ignored, no output, -> IDLE.
- EXT_BRK: any byte is ignored and not counted, -> IDLE.
- Make handling:
  - 0x12 or 0x59 (LShift/RShift): set that side's held bit.
  - 0x58: toggle caps_lock. Typematic repeats toggle again; accepted behaviour.
  - Mapped key: push its character. Typematic repeats push again.
  - Unmapped key: no push.
- Break handling:
  - 0x12 or 0x59: clear that side's held bit.
  - shift_held = LShift_held | RShift_held.
  - Breaks never push a character.
- Map for letters a..z:
  - 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Uppercase (0x41..0x5A) when shift_held XOR caps_lock, else lowercase (0x61..0x7A).
- Map for digits, unaffected by Shift/Caps:
  - 0..9 = 45 16 1E 26 25 2E 36 3D 3E 46 -> 0x30..0x39.
- Map for control keys:
  - Space 0x29 -> 0x20.
  - Enter 0x5A -> 0x0D.
  - Backspace 0x66 -> 0x08.
- Shift/Caps state used for a letter is the state before the current byte.
- FIFO:
  - Show-ahead; pop on ascii_valid && ascii_ready.
  - Push accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped and overflow is set.
  - Pop on empty: no effect.
  - Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- Reset mid-operation:
  - FSM -> IDLE; FIFO emptied; all outputs cleared.
  - A prefix received before reset is forgotten.

## Timing
- Reset values:
  - ascii=0x00, ascii_valid=0, shift_held=0, caps_lock=0, key_count=0, overflow=0.
  - FSM=IDLE, FIFO count=0.
- Pipeline: clock edge E samples code_in; a one-stage decode register holds char/push. The push writes the FIFO at edge E+1.
- ascii/ascii_valid reflect the new character after edge E+1, i.e. 2-cycle latency from code_valid to ascii_valid on an empty FIFO.
- shift_held, caps_lock and key_count update at edge E (1-cycle).
- Pop at edge P: the next entry (or 0x00/invalid) appears after P.
- Back-to-back code_valid on consecutive cycles is supported. Bytes arriving at one per cycle are each processed.
- overflow is set at the dropping edge and stays set until rst.

## Test plan
- Reset, then code 0x1C, ascii_ready=0 -> after 2 cycles ascii_valid=1, ascii=0x61. Then F0,1C -> no new char, key_count=1.
- Codes 12,1C,F0,12,1C with ascii_ready=1 -> characters 0x41 then 0x61, shift_held 1 then 0. Same sequence with caps_lock set (58,F0,58 first) -> 0x61 then 0x41.
- Codes E0,75,E0,F0,75 -> no characters; key_count unchanged; FSM back in IDLE (a following 0x45 yields 0x30).
- DEPTH=8, ascii_ready=0, nine 0x16 makes -> 8 entries of 0x31, ascii_valid=1, overflow=1. Hold ascii_ready=1 for 8 cycles -> drains, ascii_valid=0, ascii=0x00, overflow stays 1.
- FIFO full with ascii_ready=1 during the cycle a push arrives -> push accepted, count stays 8, overflow stays 0.
- Send 0xF0, then assert rst for 1 cycle, then 0x1C -> character 0x61 emitted (prefix discarded), key_count=0. 256 release pairs (F0,1C) -> key_count wraps to 0.
